// File: rtl/exception_unit_pkg.sv
// Shared exception-unit types and syndrome codes used by exception_unit and the core controller.
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HANDLER = 2'd2
  } state_e;

  localparam logic [3:0] ESR_NONE   = 4'b0000;
  localparam logic [3:0] ESR_INVOP  = 4'b0010;
  localparam logic [3:0] ESR_EXTIRQ = 4'b1000;

endpackage

// File: rtl/exception_unit_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins; purely combinational.
module irq_prio_enc #(
  parameter int unsigned N_IRQ = 4,
  parameter int unsigned ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic [N_IRQ-1:0] req,
  output logic             valid_c,
  output logic [ID_W-1:0]  idx_c
);

  // Scan from the top down so the lowest index is the last (winning) assignment.
  always_comb begin
    valid_c = |req;
    idx_c   = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (req[i]) idx_c = ID_W'(i);
    end
  end

endmodule

// File: rtl/exception_unit.sv
// Exception/interrupt unit: edge-queues external IRQs, arbitrates by fixed priority, holds ELR/ESR.
// Optional build macro EXC_IRQ_MASK_EN adds a writable per-line IRQ mask.
module exception_unit
  import exc_pkg::*;
#(
  parameter int unsigned N_IRQ = 4,
  parameter int unsigned PC_W  = 64,
  parameter int unsigned ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_lines,
  input  logic [PC_W-1:0]  pc,
  input  logic             exc,
  input  logic [3:0]       estatus,
  input  logic             eret,
  input  logic             ext_iack,
`ifdef EXC_IRQ_MASK_EN
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
`endif
  output logic             ext_irq,
  output logic             exc_ack,
  output logic [PC_W-1:0]  elr,
  output logic [3:0]       esr,
  output logic [ID_W-1:0]  irq_id,
  output logic             in_handler,
  output logic             double_fault
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_REQ     = REQ;
  localparam logic [1:0] ST_HANDLER = HANDLER;

  logic [1:0]       state_q, state_d;
  logic [N_IRQ-1:0] pend, prev_lines, pend_clr, mask;
  logic             prio_valid;
  logic [ID_W-1:0]  sel_id;
  logic [PC_W-1:0]  elr_d;
  logic [3:0]       esr_d;
  logic [ID_W-1:0]  irq_id_d;
  logic             exc_ack_d, double_fault_d, ext_irq_d, in_handler_d;

`ifdef EXC_IRQ_MASK_EN
  always_ff @(posedge clk) begin
    if (reset)        mask <= '1;
    else if (mask_we) mask <= mask_wdata;
  end
`else
  assign mask = '1;
`endif

  irq_prio_enc #(.N_IRQ(N_IRQ), .ID_W(ID_W)) u_prio (
    .req     (pend & mask),
    .valid_c (prio_valid),
    .idx_c   (sel_id)
  );

  // Next-state and next-output logic; exc outranks a same-cycle iack, eret outranks exc.
  always_comb begin
    state_d        = state_q;
    elr_d          = elr;
    esr_d          = esr;
    irq_id_d       = irq_id;
    exc_ack_d      = 1'b0;
    double_fault_d = double_fault;
    pend_clr       = '0;
    case (state_q)
      ST_IDLE: begin
        if (exc) begin
          state_d   = ST_HANDLER;
          elr_d     = pc;
          esr_d     = estatus;
          exc_ack_d = 1'b1;
        end else if (prio_valid) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (exc) begin
          state_d   = ST_HANDLER;
          elr_d     = pc;
          esr_d     = estatus;
          exc_ack_d = 1'b1;
        end else if (!prio_valid) begin
          state_d = ST_IDLE;
        end else if (ext_iack) begin
          state_d  = ST_HANDLER;
          elr_d    = pc;
          esr_d    = ESR_EXTIRQ;
          irq_id_d = sel_id;
          pend_clr = N_IRQ'(1) << sel_id;
        end
      end
      ST_HANDLER: begin
        if (eret) begin
          state_d = ST_IDLE;
        end else if (exc) begin
          double_fault_d = 1'b1;
          exc_ack_d      = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ext_irq_d    = (state_d == ST_REQ);
    in_handler_d = (state_d == ST_HANDLER);
  end

  // A fresh edge on a line being cleared this cycle keeps it pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pend         <= '0;
      prev_lines   <= '0;
      ext_irq      <= 1'b0;
      exc_ack      <= 1'b0;
      elr          <= '0;
      esr          <= '0;
      irq_id       <= '0;
      in_handler   <= 1'b0;
      double_fault <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend         <= (pend & ~pend_clr) | (irq_lines & ~prev_lines);
      prev_lines   <= irq_lines;
      ext_irq      <= ext_irq_d;
      exc_ack      <= exc_ack_d;
      elr          <= elr_d;
      esr          <= esr_d;
      irq_id       <= irq_id_d;
      in_handler   <= in_handler_d;
      double_fault <= double_fault_d;
    end
  end

endmodule

// File: tb/tb_exception_unit.sv
// Directed self-checking bench for exception_unit (N_IRQ=4, PC_W=64).
module tb_exception_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_lines;
  logic [63:0] pc;
  logic        exc;
  logic [3:0]  estatus;
  logic        eret;
  logic        ext_iack;
  logic        ext_irq, exc_ack, in_handler, double_fault;
  logic [63:0] elr;
  logic [3:0]  esr;
  logic [1:0]  irq_id;
`ifdef EXC_IRQ_MASK_EN
  logic        mask_we;
  logic [3:0]  mask_wdata;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exception_unit #(.N_IRQ(4), .PC_W(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .irq_lines    (irq_lines),
    .pc           (pc),
    .exc          (exc),
    .estatus      (estatus),
    .eret         (eret),
    .ext_iack     (ext_iack),
`ifdef EXC_IRQ_MASK_EN
    .mask_we      (mask_we),
    .mask_wdata   (mask_wdata),
`endif
    .ext_irq      (ext_irq),
    .exc_ack      (exc_ack),
    .elr          (elr),
    .esr          (esr),
    .irq_id       (irq_id),
    .in_handler   (in_handler),
    .double_fault (double_fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; irq_lines = '0; pc = '0; exc = 1'b0; estatus = '0;
    eret = 1'b0; ext_iack = 1'b0;
`ifdef EXC_IRQ_MASK_EN
    mask_we = 1'b0; mask_wdata = '0;
`endif
    step(); step();
    reset = 1'b0;
    chk("rst_ext_irq", 64'(ext_irq), 64'd0);
    chk("rst_exc_ack", 64'(exc_ack), 64'd0);
    chk("rst_elr", elr, 64'd0);
    chk("rst_esr", 64'(esr), 64'd0);
    chk("rst_in_handler", 64'(in_handler), 64'd0);
    chk("rst_double_fault", 64'(double_fault), 64'd0);

    // Single IRQ on line 2
    pc = 64'h40; irq_lines = 4'b0100; step();
    irq_lines = 4'b0000; step();
    chk("t1_ext_irq", 64'(ext_irq), 64'd1);
    ext_iack = 1'b1; step(); ext_iack = 1'b0;
    chk("t1_elr", elr, 64'h40);
    chk("t1_esr", 64'(esr), 64'h8);
    chk("t1_irq_id", 64'(irq_id), 64'd2);
    chk("t1_ext_irq_drop", 64'(ext_irq), 64'd0);
    chk("t1_in_handler", 64'(in_handler), 64'd1);
    eret = 1'b1; step(); eret = 1'b0;
    chk("t1_eret_idle", 64'(in_handler), 64'd0);
    step();
    chk("t1_no_req", 64'(ext_irq), 64'd0);

    // Simultaneous edges on lines 3 and 1
    irq_lines = 4'b1010; step();
    irq_lines = 4'b0000; step();
    chk("t2_ext_irq", 64'(ext_irq), 64'd1);
    ext_iack = 1'b1; step(); ext_iack = 1'b0;
    chk("t2_first_id", 64'(irq_id), 64'd1);
    step();
    chk("t2_no_nest", 64'(ext_irq), 64'd0);
    eret = 1'b1; step(); eret = 1'b0;
    step();
    chk("t2_rearm", 64'(ext_irq), 64'd1);
    ext_iack = 1'b1; step(); ext_iack = 1'b0;
    chk("t2_second_id", 64'(irq_id), 64'd3);
    eret = 1'b1; step(); eret = 1'b0;

    // exc beats a same-cycle iack in REQ
    irq_lines = 4'b0001; step();
    irq_lines = 4'b0000; step();
    chk("t3_ext_irq", 64'(ext_irq), 64'd1);
    pc = 64'h100; exc = 1'b1; estatus = 4'b0010; ext_iack = 1'b1; step();
    exc = 1'b0; ext_iack = 1'b0;
    chk("t3_exc_ack", 64'(exc_ack), 64'd1);
    chk("t3_esr", 64'(esr), 64'h2);
    chk("t3_elr", elr, 64'h100);
    chk("t3_ext_irq_drop", 64'(ext_irq), 64'd0);
    chk("t3_irq_id_kept", 64'(irq_id), 64'd3);
    step();
    chk("t3_ack_one_cycle", 64'(exc_ack), 64'd0);
    eret = 1'b1; step(); eret = 1'b0;
    step();
    chk("t3_pend_kept", 64'(ext_irq), 64'd1);
    ext_iack = 1'b1; step(); ext_iack = 1'b0;
    chk("t3_irq_id", 64'(irq_id), 64'd0);
    chk("t3_esr_ext", 64'(esr), 64'h8);

    // Double fault in HANDLER, then eret+exc together
    pc = 64'h200; exc = 1'b1; estatus = 4'b0010; step(); exc = 1'b0;
    chk("t4_double_fault", 64'(double_fault), 64'd1);
    chk("t4_exc_ack", 64'(exc_ack), 64'd1);
    chk("t4_elr_kept", elr, 64'h100);
    chk("t4_esr_kept", 64'(esr), 64'h8);
    step();
    chk("t4_ack_drop", 64'(exc_ack), 64'd0);
    eret = 1'b1; exc = 1'b1; step(); eret = 1'b0; exc = 1'b0;
    chk("t4_eret_wins_ack", 64'(exc_ack), 64'd0);
    chk("t4_eret_wins_idle", 64'(in_handler), 64'd0);
    chk("t4_df_sticky", 64'(double_fault), 64'd1);

    // Reset in HANDLER with pend=0011
    exc = 1'b1; estatus = 4'b0010; step(); exc = 1'b0;
    chk("t5_in_handler", 64'(in_handler), 64'd1);
    irq_lines = 4'b0011; step();
    reset = 1'b1; step();
    chk("t5_rst_ext_irq", 64'(ext_irq), 64'd0);
    chk("t5_rst_in_handler", 64'(in_handler), 64'd0);
    chk("t5_rst_double_fault", 64'(double_fault), 64'd0);
    chk("t5_rst_elr", elr, 64'd0);
    chk("t5_rst_esr", 64'(esr), 64'd0);
    chk("t5_rst_irq_id", 64'(irq_id), 64'd0);
    reset = 1'b0; irq_lines = 4'b0000; step(); step();
    chk("t5_pend_cleared", 64'(ext_irq), 64'd0);

    // Line high across reset is captured one cycle after release
    reset = 1'b1; irq_lines = 4'b0100; step();
    reset = 1'b0; step();
    chk("t6_edge_after_rst", 64'(ext_irq), 64'd0);
    irq_lines = 4'b0000; step();
    chk("t6_req", 64'(ext_irq), 64'd1);
    pc = 64'h80; ext_iack = 1'b1; step(); ext_iack = 1'b0;
    chk("t6_irq_id", 64'(irq_id), 64'd2);
    chk("t6_elr", elr, 64'h80);
    eret = 1'b1; step(); eret = 1'b0;

`ifdef EXC_IRQ_MASK_EN
    mask_we = 1'b1; mask_wdata = 4'b1110; step(); mask_we = 1'b0;
    irq_lines = 4'b0001; step();
    irq_lines = 4'b0000; step(); step();
    chk("m_masked", 64'(ext_irq), 64'd0);
    mask_we = 1'b1; mask_wdata = 4'b1111; step(); mask_we = 1'b0;
    step();
    chk("m_unmasked", 64'(ext_irq), 64'd1);
    ext_iack = 1'b1; step(); ext_iack = 1'b0;
    chk("m_irq_id", 64'(irq_id), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
